ps2_kbd_events: RTL and testbench

PS/2 keyboard receiver and scan-code event decoder, the parametrised successor to the keyboard front end that drives the key/ASCII/count seven-segment displays. It deserialises PS/2 frames, checks them, and resolves E0/F0 prefixes into make/break events with an extended flag. It tracks the currently held key with repeat suppression and counts distinct presses. Events are buffered in a FIFO behind a valid/ready port so slower consumers (display, ASCII mapper, CPU bridge) lose nothing.

---
 rtl/ps2_kbd_events_if.sv | 11 +
 rtl/ps2_kbd_events.sv | 203 ++++++++++++++++++++
 tb/tb_ps2_kbd_events.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_kbd_events_if.sv
// Event stream port of the PS/2 keyboard front end: FIFO head plus consumer handshake.
interface ps2_kbd_events_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_brk;

  modport master (output ev_valid, ev_code, ev_ext, ev_brk, input ev_ready);
  modport slave  (input ev_valid, ev_code, ev_ext, ev_brk, output ev_ready);
endinterface

// File: rtl/ps2_kbd_events.sv
// PS/2 keyboard receiver: frame deserialiser, E0/F0 prefix decoder, held-key tracker
// and a first-word-fall-through event FIFO.
module ps2_kbd_events #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  ps2_kbd_events_if.master ev,
  output logic             is_press,
  output logic [7:0]       key,
  output logic             key_ext,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  // Frame layout {stop, parity, d7..d0, start}; odd parity over data plus parity bit.
  function automatic logic frame_ok(input logic [10:0] f);
    return (f[0] == 1'b0) && (f[10] == 1'b1) && (^f[9:1] == 1'b1);
  endfunction

  logic         r_clk_s1, r_clk_s2, r_clk_hist;
  logic         r_dat_s1, r_dat_s2;
  logic         w_fall;
  logic [9:0]   r_shift;
  logic [10:0]  w_frame;
  logic         w_ok;
  logic [3:0]   r_bitcnt;
  logic [TW-1:0] r_idle;
  logic         r_vld_p1;
  logic [7:0]   r_byte_p1;
  logic         r_frame_err;

  state_t       r_state, w_state_nxt;
  logic         w_emit, w_ev_ext, w_ev_brk;
  logic         w_match, w_repeat, w_push;
  logic         r_is_press, r_key_ext, r_overflow;
  logic [7:0]   r_key;
  logic [CNT_W-1:0] r_count;

  logic [9:0]   r_mem [FIFO_DEPTH];
  logic [AW:0]  r_wr_ptr, r_rd_ptr;
  logic         w_empty, w_full, w_pop, w_wr_en;
  logic [9:0]   w_head;

  // Stage p0: synchronise PS/2 lines and detect the falling clock edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_hist <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_hist <= r_clk_s2;
      r_dat_s1   <= ps2_data;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign w_fall  = r_clk_hist & ~r_clk_s2;
  assign w_frame = {r_dat_s2, r_shift};
  assign w_ok    = frame_ok(w_frame);

  always_ff @(posedge clk) begin
    if (w_fall) r_shift <= {r_dat_s2, r_shift[9:1]};
    if (w_fall && (r_bitcnt == 4'd10)) r_byte_p1 <= w_frame[8:1];
  end

  // Stage p1: byte check result and frame error / timeout pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bitcnt    <= 4'd0;
      r_idle      <= '0;
      r_vld_p1    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_vld_p1    <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_fall) begin
        r_idle <= '0;
        if (r_bitcnt == 4'd10) begin
          r_bitcnt    <= 4'd0;
          r_vld_p1    <= w_ok;
          r_frame_err <= ~w_ok;
        end else begin
          r_bitcnt <= r_bitcnt + 4'd1;
        end
      end else if (r_bitcnt != 4'd0) begin
        if (r_idle == TW'(TIMEOUT - 1)) begin
          r_bitcnt    <= 4'd0;
          r_idle      <= '0;
          r_frame_err <= 1'b1;
        end else begin
          r_idle <= r_idle + TW'(1);
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    w_ev_ext    = 1'b0;
    w_ev_brk    = 1'b0;
    if (r_vld_p1) begin
      case (r_state)
        S_EXT: begin
          if (r_byte_p1 == 8'hE0)      w_state_nxt = S_EXT;
          else if (r_byte_p1 == 8'hF0) w_state_nxt = S_EXT_BRK;
          else begin
            w_emit      = 1'b1;
            w_ev_ext    = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          // A prefix arriving mid-break restarts the sequence as if from idle
          if (r_byte_p1 == 8'hE0)      w_state_nxt = S_EXT;
          else if (r_byte_p1 == 8'hF0) w_state_nxt = S_BRK;
          else begin
            w_emit      = 1'b1;
            w_ev_ext    = (r_state == S_EXT_BRK);
            w_ev_brk    = (r_state != S_IDLE);
            w_state_nxt = S_IDLE;
          end
        end
      endcase
    end
  end

  assign w_match  = ({w_ev_ext, r_byte_p1} == {r_key_ext, r_key});
  assign w_repeat = w_emit & ~w_ev_brk & r_is_press & w_match;
  assign w_push   = w_emit & ~w_repeat;

  // Stage p2: decoder state, held-key tracking and FIFO write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_is_press <= 1'b0;
      r_key      <= 8'h00;
      r_key_ext  <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push && !w_ev_brk) begin
        r_key      <= r_byte_p1;
        r_key_ext  <= w_ev_ext;
        r_is_press <= 1'b1;
        r_count    <= r_count + CNT_W'(1);
      end else if (w_push && w_match) begin
        r_is_press <= 1'b0;
      end
    end
  end

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = ~w_empty & ev.ev_ready;
  assign w_wr_en = w_push & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= {w_ev_ext, w_ev_brk, r_byte_p1};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign w_head      = r_mem[r_rd_ptr[AW-1:0]];
  assign ev.ev_valid = ~w_empty;
  assign ev.ev_code  = w_empty ? 8'h00 : w_head[7:0];
  assign ev.ev_brk   = w_empty ? 1'b0  : w_head[8];
  assign ev.ev_ext   = w_empty ? 1'b0  : w_head[9];

  assign is_press  = r_is_press;
  assign key       = r_key;
  assign key_ext   = r_key_ext;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_kbd_events.sv
// Scoreboard bench for ps2_kbd_events: directed PS/2 frames, expected events queued,
// monitor pops and compares whenever the DUT hands an event over.
`timescale 1ns/1ps
module tb_ps2_kbd_events;
  localparam int HALF = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       is_press, key_ext, overflow, frame_err;
  logic [7:0] key;
  logic [3:0] count;

  ps2_kbd_events_if ev_if();

  ps2_kbd_events #(.FIFO_DEPTH(8), .CNT_W(4), .TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .ev(ev_if),
    .is_press(is_press), .key(key), .key_ext(key_ext), .count(count),
    .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int err_cnt = 0;
  logic [9:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && ev_if.ev_valid && ev_if.ev_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_event got=%0h exp=none",
                 {ev_if.ev_ext, ev_if.ev_brk, ev_if.ev_code});
      end else begin
        chk("event", {22'd0, ev_if.ev_ext, ev_if.ev_brk, ev_if.ev_code}, {22'd0, exp_q.pop_front()});
      end
    end
    if (rst && frame_err) err_cnt++;
  end

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      #(HALF);
      ps2_clk = 1'b0;
      #(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic bad_par = 1'b0, input logic bad_stop = 1'b0);
    send_bits(mk_frame(b, bad_par, bad_stop), 11);
    #(4*HALF);
  endtask

  task automatic push_exp(input logic ext, input logic brk, input logic [7:0] code);
    exp_q.push_back({ext, brk, code});
  endtask

  initial begin
    ev_if.ev_ready = 1'b1;
    #50;
    chk("rst_valid", {31'd0, ev_if.ev_valid}, 0);
    chk("rst_code", {24'd0, ev_if.ev_code}, 0);
    chk("rst_count", {28'd0, count}, 0);
    chk("rst_key", {24'd0, key}, 0);
    rst = 1'b1;
    #100;

    // make then break of 1C
    push_exp(0, 0, 8'h1C);
    send_byte(8'h1C);
    chk("t1_press", {31'd0, is_press}, 1);
    chk("t1_key", {24'd0, key}, 32'h1C);
    chk("t1_count", {28'd0, count}, 1);
    push_exp(0, 1, 8'h1C);
    send_byte(8'hF0); send_byte(8'h1C);
    chk("t1_release", {31'd0, is_press}, 0);
    chk("t1_key_kept", {24'd0, key}, 32'h1C);
    chk("t1_count2", {28'd0, count}, 1);

    // extended key 75
    push_exp(1, 0, 8'h75);
    send_byte(8'hE0); send_byte(8'h75);
    chk("t2_key_ext", {31'd0, key_ext}, 1);
    chk("t2_key", {24'd0, key}, 32'h75);
    chk("t2_count", {28'd0, count}, 2);
    push_exp(1, 1, 8'h75);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    chk("t2_release", {31'd0, is_press}, 0);
    chk("t2_count2", {28'd0, count}, 2);

    // typematic repeat: five makes, one break -> two events
    push_exp(0, 0, 8'h1C);
    push_exp(0, 1, 8'h1C);
    for (int i = 0; i < 5; i++) send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h1C);
    chk("t3_count", {28'd0, count}, 3);
    chk("t3_queue", exp_q.size(), 0);

    // bad parity and bad stop
    send_byte(8'h1C, 1'b1, 1'b0);
    send_byte(8'h1C, 1'b0, 1'b1);
    chk("t4_errs", err_cnt, 2);
    chk("t4_count", {28'd0, count}, 3);
    chk("t4_press", {31'd0, is_press}, 0);

    // 17 distinct presses with a 4-bit counter: 3+17 = 20 -> 4
    for (int i = 0; i < 17; i++) begin
      push_exp(0, 0, 8'h10 + 8'(i));
      push_exp(0, 1, 8'h10 + 8'(i));
      send_byte(8'h10 + 8'(i));
      send_byte(8'hF0); send_byte(8'h10 + 8'(i));
    end
    chk("t5_count_wrap", {28'd0, count}, 4);
    chk("t5_queue", exp_q.size(), 0);

    // stalled consumer: nine makes into an eight-entry FIFO
    ev_if.ev_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) push_exp(0, 0, 8'h30 + 8'(i));
      send_byte(8'h30 + 8'(i));
    end
    chk("t6_valid", {31'd0, ev_if.ev_valid}, 1);
    chk("t6_overflow", {31'd0, overflow}, 1);
    chk("t6_head", {24'd0, ev_if.ev_code}, 32'h30);
    chk("t6_key", {24'd0, key}, 32'h38);
    chk("t6_count", {28'd0, count}, 13);
    ev_if.ev_ready = 1'b1;
    #500;
    chk("t6_drained", exp_q.size(), 0);
    chk("t6_empty", {31'd0, ev_if.ev_valid}, 0);

    // partial frame then silence beyond the timeout
    send_bits(mk_frame(8'h1C, 1'b0, 1'b0), 6);
    #2000;
    chk("t7_timeout_err", err_cnt, 3);
    push_exp(0, 0, 8'h1C);
    send_byte(8'h1C);
    chk("t7_key", {24'd0, key}, 32'h1C);
    chk("t7_count", {28'd0, count}, 14);

    // reset with a pending E0 prefix and a partial frame
    send_byte(8'hE0);
    send_bits(mk_frame(8'h1C, 1'b0, 1'b0), 5);
    rst = 1'b0;
    #50;
    chk("t8_valid", {31'd0, ev_if.ev_valid}, 0);
    chk("t8_press", {31'd0, is_press}, 0);
    chk("t8_key", {24'd0, key}, 0);
    chk("t8_key_ext", {31'd0, key_ext}, 0);
    chk("t8_count", {28'd0, count}, 0);
    chk("t8_overflow", {31'd0, overflow}, 0);
    chk("t8_ferr", {31'd0, frame_err}, 0);
    rst = 1'b1;
    #100;
    push_exp(0, 0, 8'h1C);
    send_byte(8'h1C);
    chk("t8_key_after", {24'd0, key}, 32'h1C);
    chk("t8_ext_after", {31'd0, key_ext}, 0);
    chk("t8_count_after", {28'd0, count}, 1);
    chk("t8_errs", err_cnt, 3);

    #500;
    chk("final_queue", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
